// File: rtl/mc_issue_scheduler_if.sv
// mc_issue_scheduler_if: thread issue request/grant handshake and multi-cycle writeback report.
interface mc_issue_scheduler_if #(
    parameter int THREADS = 4
);
    localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;
    logic [THREADS-1:0] ts_request;
    logic [THREADS-1:0] ts_is_multicycle;
    logic [THREADS-1:0] issue_grant;
    logic               issue_valid;
    logic               issue_is_multicycle;
    logic [THREADS-1:0] mc_busy;
    logic               mc_wb_valid;
    logic [TW-1:0]      mc_wb_thread;
    modport master (
        output ts_request, ts_is_multicycle,
        input  issue_grant, issue_valid, issue_is_multicycle, mc_busy, mc_wb_valid, mc_wb_thread
    );
    modport slave (
        input  ts_request, ts_is_multicycle,
        output issue_grant, issue_valid, issue_is_multicycle, mc_busy, mc_wb_valid, mc_wb_thread
    );
endinterface

// File: rtl/mc_issue_scheduler.sv
// mc_issue_scheduler: round-robin issue arbiter with writeback-slot reservation and per-thread multi-cycle caps.
// Optional statistics counters are enabled by defining MC_ISSUE_STATS_EN.
module mc_issue_scheduler #(
    parameter int THREADS      = 4,
    parameter int LONG_LAT     = 5,
    parameter int SHORT_LAT    = 1,
    parameter int MAX_INFLIGHT = 2
) (
    input logic                 clk,
    input logic                 reset,
    mc_issue_scheduler_if.slave sched
`ifdef MC_ISSUE_STATS_EN
    ,
    output logic [31:0]         stat_grant_count,
    output logic [31:0]         stat_wb_conflict_count,
    output logic [31:0]         stat_inflight_stall_count
`endif
);
    localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;

    logic [LONG_LAT:1]  res_q, res_d, mc_q, mc_d;
    logic [TW-1:0]      tid_q [1:LONG_LAT];
    logic [TW-1:0]      tid_d [1:LONG_LAT];
    logic [2:0]         inflight_q [THREADS];
    logic [2:0]         inflight_d [THREADS];
    logic [TW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               mc_wb_valid_q;
    logic [TW-1:0]      mc_wb_thread_q;
    logic [THREADS-1:0] mc_busy_q, mc_busy_d;
    logic [THREADS-1:0] wb_blk, cap_blk, elig, inc, dec;
    logic [LONG_LAT:0]  lat_set;
    logic [TW-1:0]      win;
    logic               found, issue, mc_issue, retire;

    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            wb_blk[t]  = sched.ts_is_multicycle[t] ? res_q[LONG_LAT] : res_q[SHORT_LAT];
            cap_blk[t] = sched.ts_is_multicycle[t] && (inflight_q[t] >= 3'(MAX_INFLIGHT));
            elig[t]    = sched.ts_request[t] && !wb_blk[t] && !cap_blk[t];
        end
    end

    // Search starts just past the last winner so every thread gets a turn.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr_q;
        for (int i = 1; i <= THREADS; i++) begin
            if (!found && elig[(int'(rr_ptr_q) + i) % THREADS]) begin
                found = 1'b1;
                win   = TW'((int'(rr_ptr_q) + i) % THREADS);
            end
        end
    end

    assign issue    = found && !reset;
    assign mc_issue = issue && sched.ts_is_multicycle[win];
    assign retire   = res_q[1] && mc_q[1];
    assign rr_ptr_d = issue ? win : rr_ptr_q;

    assign sched.issue_grant         = issue ? (THREADS'(1) << win) : '0;
    assign sched.issue_valid         = issue;
    assign sched.issue_is_multicycle = mc_issue;
    assign sched.mc_busy             = mc_busy_q;
    assign sched.mc_wb_valid         = mc_wb_valid_q;
    assign sched.mc_wb_thread        = mc_wb_thread_q;

    // A latency-L grant lands in slot L-1 after the edge; a latency-1 op needs no stored slot.
    always_comb begin
        lat_set = '0;
        lat_set[mc_issue ? LONG_LAT : SHORT_LAT] = issue;
        res_d = {1'b0, res_q[LONG_LAT:2] | lat_set[LONG_LAT:2]};
        mc_d  = {1'b0, mc_q[LONG_LAT:2]};
        mc_d[LONG_LAT-1] = mc_d[LONG_LAT-1] | mc_issue;
        for (int k = 1; k < LONG_LAT; k++) tid_d[k] = tid_q[k+1];
        tid_d[LONG_LAT] = '0;
        if (mc_issue) tid_d[LONG_LAT-1] = win;
    end

    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            inc[t]        = mc_issue && (win == TW'(t));
            dec[t]        = retire && (tid_q[1] == TW'(t));
            inflight_d[t] = inflight_q[t] + {2'b0, inc[t]} - {2'b0, dec[t]};
            mc_busy_d[t]  = inflight_d[t] != 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q          <= '0;
            mc_q           <= '0;
            tid_q          <= '{default: '0};
            inflight_q     <= '{default: '0};
            rr_ptr_q       <= TW'(THREADS - 1);
            mc_wb_valid_q  <= 1'b0;
            mc_wb_thread_q <= '0;
            mc_busy_q      <= '0;
        end else begin
            res_q          <= res_d;
            mc_q           <= mc_d;
            tid_q          <= tid_d;
            inflight_q     <= inflight_d;
            rr_ptr_q       <= rr_ptr_d;
            mc_wb_valid_q  <= retire;
            mc_wb_thread_q <= retire ? tid_q[1] : mc_wb_thread_q;
            mc_busy_q      <= mc_busy_d;
        end
    end

`ifdef MC_ISSUE_STATS_EN
    logic [31:0] grant_cnt_q, conflict_cnt_q, stall_cnt_q;
    logic        conflict, stall;

    assign conflict = |(sched.ts_request & wb_blk & ~cap_blk);
    assign stall    = |(sched.ts_request & cap_blk & ~wb_blk);

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_q + {31'b0, issue};
            conflict_cnt_q <= conflict_cnt_q + {31'b0, conflict};
            stall_cnt_q    <= stall_cnt_q + {31'b0, stall};
        end
    end

    assign stat_grant_count          = grant_cnt_q;
    assign stat_wb_conflict_count    = conflict_cnt_q;
    assign stat_inflight_stall_count = stall_cnt_q;
`endif
endmodule
